// File: rtl/sha3_row_bus_arbiter_if.sv
// SHA3 row bus: 25 x 64-bit lanes as rows a..e (5 lanes each) plus a one-cycle sample strobe.
interface sha3_row_bus_arbiter_if;
   logic [4:0][63:0] a;
   logic [4:0][63:0] b;
   logic [4:0][63:0] c;
   logic [4:0][63:0] d;
   logic [4:0][63:0] e;
   logic             sample;

   modport controller (output a, b, c, d, e, sample);
   modport periph     (input  a, b, c, d, e, sample);
endinterface

// File: rtl/sha3_row_bus_arbiter.sv
// Shares one Keccak-f[1600] core between two row-bus requesters and routes results back by tag.
// Define SHA3_ARB_STRICT_PRIO_EN for fixed priority (req0 wins ties); default is round-robin.
module sha3_row_bus_arbiter #(
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   sha3_row_bus_arbiter_if.periph            req0,
   sha3_row_bus_arbiter_if.periph            req1,
   output logic                              busy0,
   output logic                              busy1,
   sha3_row_bus_arbiter_if.controller        core_in,
   input  logic                              core_ready,
   sha3_row_bus_arbiter_if.periph            core_out,
   sha3_row_bus_arbiter_if.controller        res0,
   sha3_row_bus_arbiter_if.controller        res1,
   output logic                              ovf0,
   output logic                              ovf1,
   output logic                              orphan
);

   localparam int PW = $clog2(MAX_INFLIGHT);
   localparam int CW = PW + 1;

   // Lane k lives at index k; rows a..e occupy lanes 0-4, 5-9, ... 20-24.
   logic [24:0][63:0] req_lanes [2];
   logic [24:0][63:0] core_lanes;
   logic [1:0]        req_sample;

   logic [1:0]        slot_full;
   logic [24:0][63:0] slot_data [2];
   logic [1:0]        ovf;

   logic              cin_sample;
   logic [24:0][63:0] cin_lanes;
   logic [1:0]        res_sample;
   logic [24:0][63:0] res_lanes [2];
   logic              orphan_q;

   logic              tag_mem [MAX_INFLIGHT];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     tag_count;

   logic              dispatch;
   logic              grant;
   logic [1:0]        grant_vec;
   logic              pop;

   assign req_lanes[0] = {req0.e, req0.d, req0.c, req0.b, req0.a};
   assign req_lanes[1] = {req1.e, req1.d, req1.c, req1.b, req1.a};
   assign core_lanes   = {core_out.e, core_out.d, core_out.c, core_out.b, core_out.a};
   assign req_sample   = {req1.sample, req0.sample};

`ifdef SHA3_ARB_STRICT_PRIO_EN
   always_comb begin
      grant = !slot_full[0];
   end
`else
   logic last_grant;

   always_comb begin
      grant = (&slot_full) ? !last_grant : !slot_full[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (dispatch) begin
         last_grant <= grant;
      end
   end
`endif

   // A strobe currently on core_in blocks a new decision, giving one dispatch per two cycles.
   always_comb begin
      dispatch  = core_ready && (|slot_full) && (tag_count < CW'(MAX_INFLIGHT)) && !cin_sample;
      grant_vec = 2'b00;
      if (dispatch) begin
         grant_vec = grant ? 2'b10 : 2'b01;
      end
      pop = core_out.sample && (tag_count != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_full <= 2'b00;
         ovf       <= 2'b00;
         for (int n = 0; n < 2; n++) begin
            slot_data[n] <= '0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (req_sample[n]) begin
               if (!slot_full[n] || grant_vec[n]) begin
                  slot_data[n] <= req_lanes[n];
                  slot_full[n] <= 1'b1;
               end else begin
                  ovf[n] <= 1'b1;
               end
            end else if (grant_vec[n]) begin
               slot_full[n] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cin_sample <= 1'b0;
         cin_lanes  <= '0;
      end else begin
         cin_sample <= dispatch;
         if (dispatch) begin
            cin_lanes <= slot_data[grant];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (dispatch) begin
         tag_mem[wr_ptr] <= grant;
      end
   end

   // Count uses the registered value for both push and pop; there is no same-cycle bypass.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         tag_count <= '0;
      end else begin
         if (dispatch) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({dispatch, pop})
            2'b10:   tag_count <= tag_count + CW'(1);
            2'b01:   tag_count <= tag_count - CW'(1);
            default: tag_count <= tag_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_sample <= 2'b00;
         orphan_q   <= 1'b0;
         for (int n = 0; n < 2; n++) begin
            res_lanes[n] <= '0;
         end
      end else begin
         res_sample <= 2'b00;
         if (pop) begin
            res_sample[tag_mem[rd_ptr]] <= 1'b1;
            res_lanes[tag_mem[rd_ptr]]  <= core_lanes;
         end
         if (core_out.sample && (tag_count == '0)) begin
            orphan_q <= 1'b1;
         end
      end
   end

   assign busy0  = slot_full[0];
   assign busy1  = slot_full[1];
   assign ovf0   = ovf[0];
   assign ovf1   = ovf[1];
   assign orphan = orphan_q;

   assign core_in.sample = cin_sample;
   assign core_in.a      = cin_lanes[4:0];
   assign core_in.b      = cin_lanes[9:5];
   assign core_in.c      = cin_lanes[14:10];
   assign core_in.d      = cin_lanes[19:15];
   assign core_in.e      = cin_lanes[24:20];

   assign res0.sample = res_sample[0];
   assign res0.a      = res_lanes[0][4:0];
   assign res0.b      = res_lanes[0][9:5];
   assign res0.c      = res_lanes[0][14:10];
   assign res0.d      = res_lanes[0][19:15];
   assign res0.e      = res_lanes[0][24:20];

   assign res1.sample = res_sample[1];
   assign res1.a      = res_lanes[1][4:0];
   assign res1.b      = res_lanes[1][9:5];
   assign res1.c      = res_lanes[1][14:10];
   assign res1.d      = res_lanes[1][19:15];
   assign res1.e      = res_lanes[1][24:20];

endmodule

// File: tb/tb_sha3_row_bus_arbiter.sv
// Self-checking bench for sha3_row_bus_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_sha3_row_bus_arbiter;

   localparam int MAX_INFLIGHT = 4;

   logic clk = 1'b0;
   logic rst;
   logic core_ready;
   logic busy0, busy1, ovf0, ovf1, orphan;

   int errors = 0;
   int checks = 0;

   sha3_row_bus_arbiter_if req0_if ();
   sha3_row_bus_arbiter_if req1_if ();
   sha3_row_bus_arbiter_if core_in_if ();
   sha3_row_bus_arbiter_if core_out_if ();
   sha3_row_bus_arbiter_if res0_if ();
   sha3_row_bus_arbiter_if res1_if ();

   sha3_row_bus_arbiter #(.MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0_if),
      .req1       (req1_if),
      .busy0      (busy0),
      .busy1      (busy1),
      .core_in    (core_in_if),
      .core_ready (core_ready),
      .core_out   (core_out_if),
      .res0       (res0_if),
      .res1       (res1_if),
      .ovf0       (ovf0),
      .ovf1       (ovf1),
      .orphan     (orphan)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req0_if.sample     = 1'b0;
      req1_if.sample     = 1'b0;
      core_out_if.sample = 1'b0;
   endtask

   task automatic zero_data;
      req0_if.a = '0; req0_if.b = '0; req0_if.c = '0; req0_if.d = '0; req0_if.e = '0;
      req1_if.a = '0; req1_if.b = '0; req1_if.c = '0; req1_if.d = '0; req1_if.e = '0;
      core_out_if.a = '0; core_out_if.b = '0; core_out_if.c = '0;
      core_out_if.d = '0; core_out_if.e = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      core_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      zero_data();
      do_reset();
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
      checks++; if (core_in_if.sample !== 1'b0) begin errors++; $display("FAIL reset_cin_sample: got %b want 0", core_in_if.sample); end
      checks++; if (core_in_if.a[0] !== 64'h0) begin errors++; $display("FAIL reset_cin_a0: got %h want 0", core_in_if.a[0]); end
      checks++; if (res0_if.sample !== 1'b0 || res1_if.sample !== 1'b0) begin errors++; $display("FAIL reset_res_sample: got %b%b want 00", res1_if.sample, res0_if.sample); end
      checks++; if ({ovf1, ovf0, orphan} !== 3'b000) begin errors++; $display("FAIL reset_sticky: got %b want 000", {ovf1, ovf0, orphan}); end
   endtask

   task automatic test_basic;
      do_reset();
      core_ready = 1'b1;
      req0_if.a[0] = 64'h1;
      req0_if.e[4] = 64'hE4E4_0000_0000_00E4;
      req0_if.sample = 1'b1;                                   // cycle 0
      tick();
      req0_if.sample = 1'b0;                                   // cycle 1
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy0_c1: got %b want 1", busy0); end
      checks++; if (core_in_if.sample !== 1'b0) begin errors++; $display("FAIL basic_cin_c1: got %b want 0", core_in_if.sample); end
      tick();                                                  // cycle 2
      checks++; if (core_in_if.sample !== 1'b1) begin errors++; $display("FAIL basic_cin_c2: got %b want 1", core_in_if.sample); end
      checks++; if (core_in_if.a[0] !== 64'h1) begin errors++; $display("FAIL basic_cin_a0: got %h want 1", core_in_if.a[0]); end
      checks++; if (core_in_if.e[4] !== 64'hE4E4_0000_0000_00E4) begin errors++; $display("FAIL basic_cin_e4: got %h want e4e40000000000e4", core_in_if.e[4]); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy0_c2: got %b want 0", busy0); end
      tick();                                                  // cycle 3
      checks++; if (core_in_if.sample !== 1'b0 || core_in_if.a[0] !== 64'h1) begin errors++; $display("FAIL basic_cin_hold: got s=%b a0=%h want s=0 a0=1", core_in_if.sample, core_in_if.a[0]); end
      for (int i = 3; i < 10; i++) tick();                     // now cycle 10
      core_out_if.a[0] = 64'h1;
      core_out_if.e[4] = 64'hE4E4_0000_0000_00E4;
      core_out_if.sample = 1'b1;
      tick();                                                  // cycle 11
      core_out_if.sample = 1'b0;
      checks++; if (res0_if.sample !== 1'b1) begin errors++; $display("FAIL basic_res0_sample: got %b want 1", res0_if.sample); end
      checks++; if (res0_if.a[0] !== 64'h1 || res0_if.e[4] !== 64'hE4E4_0000_0000_00E4) begin errors++; $display("FAIL basic_res0_data: got a0=%h e4=%h want 1 / e4e40000000000e4", res0_if.a[0], res0_if.e[4]); end
      checks++; if (res1_if.sample !== 1'b0) begin errors++; $display("FAIL basic_res1_silent: got %b want 0", res1_if.sample); end
      tick();
      checks++; if (res0_if.sample !== 1'b0) begin errors++; $display("FAIL basic_res0_one_cycle: got %b want 0", res0_if.sample); end
   endtask

   task automatic test_tie;
      do_reset();
      core_ready = 1'b1;
      req0_if.a[0] = 64'hA0; req1_if.a[0] = 64'hA1;
      req0_if.sample = 1'b1; req1_if.sample = 1'b1;            // cycle 0
      tick();
      idle_inputs();                                           // cycle 1
      checks++; if ({busy1, busy0} !== 2'b11) begin errors++; $display("FAIL tie_busy_c1: got %b want 11", {busy1, busy0}); end
      tick();                                                  // cycle 2
      checks++; if (core_in_if.sample !== 1'b1 || core_in_if.a[0] !== 64'hA0) begin errors++; $display("FAIL tie_first: got s=%b a0=%h want s=1 a0=a0", core_in_if.sample, core_in_if.a[0]); end
      checks++; if ({busy1, busy0} !== 2'b10) begin errors++; $display("FAIL tie_busy_c2: got %b want 10", {busy1, busy0}); end
      tick();                                                  // cycle 3
      checks++; if (core_in_if.sample !== 1'b0) begin errors++; $display("FAIL tie_gap: got %b want 0", core_in_if.sample); end
      tick();                                                  // cycle 4
      checks++; if (core_in_if.sample !== 1'b1 || core_in_if.a[0] !== 64'hA1) begin errors++; $display("FAIL tie_second: got s=%b a0=%h want s=1 a0=a1", core_in_if.sample, core_in_if.a[0]); end
      core_out_if.a[0] = 64'hB0; core_out_if.sample = 1'b1;    // cycle 4 result
      tick();                                                  // cycle 5
      checks++; if (res0_if.sample !== 1'b1 || res1_if.sample !== 1'b0 || res0_if.a[0] !== 64'hB0) begin errors++; $display("FAIL tie_res_first: got r0=%b r1=%b a0=%h want 1 0 b0", res0_if.sample, res1_if.sample, res0_if.a[0]); end
      core_out_if.a[0] = 64'hB1;
      tick();                                                  // cycle 6
      core_out_if.sample = 1'b0;
      checks++; if (res1_if.sample !== 1'b1 || res0_if.sample !== 1'b0 || res1_if.a[0] !== 64'hB1) begin errors++; $display("FAIL tie_res_second: got r0=%b r1=%b a0=%h want 0 1 b1", res0_if.sample, res1_if.sample, res1_if.a[0]); end
      checks++; if (res0_if.a[0] !== 64'hB0) begin errors++; $display("FAIL tie_res0_hold: got %h want b0", res0_if.a[0]); end
   endtask

   task automatic test_overflow;
      do_reset();
      core_ready = 1'b0;
      req1_if.a[0] = 64'h11; req1_if.sample = 1'b1;            // cycle 0
      tick();
      req1_if.a[0] = 64'h22;                                   // cycle 1, slot full
      tick();
      idle_inputs();                                           // cycle 2
      checks++; if (ovf1 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL ovf_flags: got ovf1=%b busy1=%b want 1 1", ovf1, busy1); end
      checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_other: got %b want 0", ovf0); end
      core_ready = 1'b1;
      tick();                                                  // cycle 3
      checks++; if (core_in_if.sample !== 1'b1 || core_in_if.a[0] !== 64'h11) begin errors++; $display("FAIL ovf_dispatch: got s=%b a0=%h want s=1 a0=11", core_in_if.sample, core_in_if.a[0]); end
      tick(); tick();                                          // cycle 5
      checks++; if (core_in_if.sample !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL ovf_single: got s=%b busy1=%b want 0 0", core_in_if.sample, busy1); end
      checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf1); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      core_ready = 1'b1;
      req0_if.a[0] = 64'h40; req0_if.sample = 1'b1;            // cycle 0
      tick();
      req0_if.a[0] = 64'h41;                                   // cycle 1: slot dispatched this cycle
      tick();
      idle_inputs();                                           // cycle 2
      checks++; if (busy0 !== 1'b1 || ovf0 !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy0=%b ovf0=%b want 1 0", busy0, ovf0); end
      checks++; if (core_in_if.sample !== 1'b1 || core_in_if.a[0] !== 64'h40) begin errors++; $display("FAIL b2b_first: got s=%b a0=%h want 1 40", core_in_if.sample, core_in_if.a[0]); end
      tick();                                                  // cycle 3
      checks++; if (core_in_if.sample !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL b2b_spacing: got s=%b busy0=%b want 0 1", core_in_if.sample, busy0); end
      tick();                                                  // cycle 4
      checks++; if (core_in_if.sample !== 1'b1 || core_in_if.a[0] !== 64'h41) begin errors++; $display("FAIL b2b_second: got s=%b a0=%h want 1 41", core_in_if.sample, core_in_if.a[0]); end
   endtask

   task automatic test_fifo_full;
      logic [63:0] seen[$];
      int sent;
      do_reset();
      core_ready = 1'b1;
      sent = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy0 && sent < 5) begin
            req0_if.a[0] = 64'h50 + 64'(sent);
            req0_if.sample = 1'b1;
            sent++;
         end else begin
            req0_if.sample = 1'b0;
         end
         tick();
         if (core_in_if.sample === 1'b1) seen.push_back(core_in_if.a[0]);
      end
      idle_inputs();
      checks++; if (seen.size() != 4) begin errors++; $display("FAIL fifo_dispatch_count: got %0d want 4", seen.size()); end
      for (int i = 0; i < seen.size() && i < 4; i++) begin
         checks++; if (seen[i] !== 64'h50 + 64'(i)) begin errors++; $display("FAIL fifo_order_%0d: got %h want %h", i, seen[i], 64'h50 + 64'(i)); end
      end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL fifo_stall_busy: got %b want 1", busy0); end
      core_out_if.a[0] = 64'h99; core_out_if.sample = 1'b1;    // cycle k
      tick();                                                  // cycle k+1
      core_out_if.sample = 1'b0;
      checks++; if (res0_if.sample !== 1'b1 || res0_if.a[0] !== 64'h99) begin errors++; $display("FAIL fifo_pop: got s=%b a0=%h want 1 99", res0_if.sample, res0_if.a[0]); end
      checks++; if (core_in_if.sample !== 1'b0) begin errors++; $display("FAIL fifo_not_yet: got %b want 0", core_in_if.sample); end
      tick();                                                  // cycle k+2
      checks++; if (core_in_if.sample !== 1'b1 || core_in_if.a[0] !== 64'h54) begin errors++; $display("FAIL fifo_release: got s=%b a0=%h want 1 54", core_in_if.sample, core_in_if.a[0]); end
   endtask

   task automatic test_orphan;
      do_reset();
      core_out_if.a[0] = 64'h77; core_out_if.sample = 1'b1;
      tick();
      core_out_if.sample = 1'b0;
      checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL orphan_set: got %b want 1", orphan); end
      checks++; if (res0_if.sample !== 1'b0 || res1_if.sample !== 1'b0) begin errors++; $display("FAIL orphan_no_res: got %b%b want 00", res1_if.sample, res0_if.sample); end
      tick();
      checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", orphan); end
   endtask

   task automatic test_reset_midflight;
      do_reset();
      core_ready = 1'b1;
      req0_if.a[0] = 64'h60; req1_if.a[0] = 64'h61;
      req0_if.sample = 1'b1; req1_if.sample = 1'b1;            // cycle 0
      tick();
      idle_inputs();
      tick(); tick(); tick();                                  // cycle 4: two tags in flight
      req0_if.a[0] = 64'h62; req1_if.a[0] = 64'h63;
      req0_if.sample = 1'b1; req1_if.sample = 1'b1;
      core_ready = 1'b0;
      tick();                                                  // cycle 5
      req1_if.sample = 1'b0;
      checks++; if ({busy1, busy0} !== 2'b11) begin errors++; $display("FAIL mid_busy: got %b want 11", {busy1, busy0}); end
      tick();                                                  // cycle 6
      req0_if.sample = 1'b0;
      checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL mid_ovf: got %b want 1", ovf0); end
      rst = 1'b1;
      tick();                                                  // cycle 7
      rst = 1'b0;
      checks++; if ({busy1, busy0, ovf1, ovf0, orphan} !== 5'b0) begin errors++; $display("FAIL mid_flags: got %b want 00000", {busy1, busy0, ovf1, ovf0, orphan}); end
      checks++; if (core_in_if.sample !== 1'b0 || core_in_if.a[0] !== 64'h0) begin errors++; $display("FAIL mid_cin: got s=%b a0=%h want 0 0", core_in_if.sample, core_in_if.a[0]); end
      core_out_if.a[0] = 64'h88; core_out_if.sample = 1'b1;
      tick();                                                  // cycle 8
      core_out_if.sample = 1'b0;
      checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL mid_orphan: got %b want 1", orphan); end
      checks++; if (res0_if.sample !== 1'b0 || res1_if.sample !== 1'b0) begin errors++; $display("FAIL mid_no_res: got %b%b want 00", res1_if.sample, res0_if.sample); end
   endtask

   // Reference model: slots, a queue of issued requester IDs, and the spec's dispatch rules.
   task automatic test_random;
      bit          m_full [2];
      logic [63:0] m_a0 [2];
      logic [63:0] m_e4 [2];
      bit          m_last;
      int          tag_q[$];
      logic [63:0] exp_q[$];
      bit          m_cin_s;
      logic [63:0] m_cin_a0, m_cin_e4;
      bit          m_res_s [2];
      logic [63:0] m_res_a0 [2];
      bit          m_ovf [2];
      bit          m_orph;
      bit          s [2];
      logic [63:0] da [2];
      logic [63:0] de [2];
      bit          cr, os, disp, freed;
      logic [63:0] oa;
      int          g, t;

      do_reset();
      m_full = '{0, 0}; m_a0 = '{0, 0}; m_e4 = '{0, 0}; m_last = 1'b1;
      m_cin_s = 0; m_cin_a0 = 0; m_cin_e4 = 0;
      m_res_s = '{0, 0}; m_res_a0 = '{0, 0}; m_ovf = '{0, 0}; m_orph = 0;
      tag_q.delete(); exp_q.delete();

      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            s[n]  = ($urandom_range(0, 2) == 0);
            da[n] = {$urandom, $urandom};
            de[n] = {$urandom, $urandom};
         end
         cr = ($urandom_range(0, 3) != 0);
         os = ($urandom_range(0, 3) == 0);
         oa = {$urandom, $urandom};
         req0_if.sample = s[0]; req0_if.a[0] = da[0]; req0_if.e[4] = de[0];
         req1_if.sample = s[1]; req1_if.a[0] = da[1]; req1_if.e[4] = de[1];
         core_ready = cr;
         core_out_if.sample = os; core_out_if.a[0] = oa;

         disp = cr && (m_full[0] || m_full[1]) && (tag_q.size() < MAX_INFLIGHT) && !m_cin_s;
`ifdef SHA3_ARB_STRICT_PRIO_EN
         g = m_full[0] ? 0 : 1;
`else
         if (m_full[0] && m_full[1]) g = m_last ? 0 : 1;
         else                        g = m_full[0] ? 0 : 1;
`endif
         m_res_s = '{0, 0};
         if (os) begin
            if (tag_q.size() > 0) begin
               t = tag_q.pop_front();
               m_res_s[t] = 1'b1;
               m_res_a0[t] = oa;
            end else begin
               m_orph = 1'b1;
            end
         end
         m_cin_s = disp;
         if (disp) begin
            m_cin_a0 = m_a0[g];
            m_cin_e4 = m_e4[g];
            tag_q.push_back(g);
            m_last = (g == 1);
         end
         for (int n = 0; n < 2; n++) begin
            freed = disp && (g == n);
            if (s[n]) begin
               if (!m_full[n] || freed) begin
                  m_full[n] = 1'b1; m_a0[n] = da[n]; m_e4[n] = de[n];
               end else begin
                  m_ovf[n] = 1'b1;
               end
            end else if (freed) begin
               m_full[n] = 1'b0;
            end
         end

         tick();

         checks++; if (busy0 !== m_full[0]) begin errors++; $display("FAIL rnd_busy0 cyc %0d: got %b want %b", cyc, busy0, m_full[0]); end
         checks++; if (busy1 !== m_full[1]) begin errors++; $display("FAIL rnd_busy1 cyc %0d: got %b want %b", cyc, busy1, m_full[1]); end
         checks++; if (core_in_if.sample !== m_cin_s) begin errors++; $display("FAIL rnd_cin_s cyc %0d: got %b want %b", cyc, core_in_if.sample, m_cin_s); end
         checks++; if (core_in_if.a[0] !== m_cin_a0) begin errors++; $display("FAIL rnd_cin_a0 cyc %0d: got %h want %h", cyc, core_in_if.a[0], m_cin_a0); end
         checks++; if (core_in_if.e[4] !== m_cin_e4) begin errors++; $display("FAIL rnd_cin_e4 cyc %0d: got %h want %h", cyc, core_in_if.e[4], m_cin_e4); end
         checks++; if (res0_if.sample !== m_res_s[0]) begin errors++; $display("FAIL rnd_res0_s cyc %0d: got %b want %b", cyc, res0_if.sample, m_res_s[0]); end
         checks++; if (res1_if.sample !== m_res_s[1]) begin errors++; $display("FAIL rnd_res1_s cyc %0d: got %b want %b", cyc, res1_if.sample, m_res_s[1]); end
         checks++; if (res0_if.a[0] !== m_res_a0[0]) begin errors++; $display("FAIL rnd_res0_a0 cyc %0d: got %h want %h", cyc, res0_if.a[0], m_res_a0[0]); end
         checks++; if (res1_if.a[0] !== m_res_a0[1]) begin errors++; $display("FAIL rnd_res1_a0 cyc %0d: got %h want %h", cyc, res1_if.a[0], m_res_a0[1]); end
         checks++; if ({ovf1, ovf0} !== {m_ovf[1], m_ovf[0]}) begin errors++; $display("FAIL rnd_ovf cyc %0d: got %b want %b", cyc, {ovf1, ovf0}, {m_ovf[1], m_ovf[0]}); end
         checks++; if (orphan !== m_orph) begin errors++; $display("FAIL rnd_orphan cyc %0d: got %b want %b", cyc, orphan, m_orph); end
      end
      idle_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      core_ready = 1'b0;
      idle_inputs();
      zero_data();
      test_reset();
      test_basic();
      test_tie();
      test_overflow();
      test_back_to_back();
      test_fifo_full();
      test_orphan();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
